// File: rtl/mole_button_input.sv
// Player-side button front end for the mole game: synchronize, debounce and edge-detect 8 buttons,
// then queue presses and hand them to game logic as hole numbers 1..8 over a valid/ready port.
module mole_button_input #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] btn_raw,
    input  logic       en,
    input  logic       hit_ready,
    output logic       hit_valid,
    output logic [3:0] hit_pos,
    output logic [7:0] btn_state
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [7:0]       sync1_q, sync2_q;
    logic [7:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q [8];
    logic [CNT_W-1:0] cnt_d [8];
    logic [1:0]       warm_q;
    logic [7:0]       armed_q, armed_d;
    logic [7:0]       pending_q, pending_d;
    logic [7:0]       press;
    logic [7:0]       avail;
    logic [7:0]       take;
    logic             valid_q, valid_d;
    logic [3:0]       pos_q, pos_d;
    logic             load;
    logic             found;
    logic [2:0]       k;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            state_q   <= '0;
            warm_q    <= '0;
            armed_q   <= '0;
            pending_q <= '0;
            valid_q   <= 1'b0;
            pos_q     <= '0;
            for (int i = 0; i < 8; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= btn_raw;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            warm_q    <= {warm_q[0], 1'b1};
            armed_q   <= armed_d;
            pending_q <= pending_d;
            valid_q   <= valid_d;
            pos_q     <= pos_d;
            for (int i = 0; i < 8; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Per-bit debounce: accept a new level only after CntMax+1 consecutive differing cycles.
    always_comb begin
        state_d = state_q;
        for (int i = 0; i < 8; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != state_q[i]) begin
                if (cnt_q[i] == CntMax) begin
                    state_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // A bit is armed once it has been seen released after reset, so buttons held through
    // reset do not fire when their debounced level first rises.
    always_comb begin
        armed_d = armed_q;
        if (warm_q[1]) begin
            armed_d = armed_q | (~sync2_q & ~state_q);
        end
    end

    assign press = state_d & ~state_q & armed_q & {8{en}};
    assign avail = pending_q & {8{en}};
    assign load  = ~valid_q | hit_ready;

    always_comb begin
        found = 1'b0;
        k     = '0;
        for (int i = 0; i < 8; i++) begin
            if (!found && avail[i]) begin
                found = 1'b1;
                k     = 3'(i);
            end
        end
    end

    always_comb begin
        take    = '0;
        valid_d = valid_q;
        pos_d   = pos_q;
        if (load) begin
            if (found) begin
                valid_d = 1'b1;
                pos_d   = 4'(k) + 4'd1;
                take[k] = 1'b1;
            end else begin
                valid_d = 1'b0;
                pos_d   = '0;
            end
        end
        // A press landing on the bit being taken this edge survives the clear.
        pending_d = en ? ((pending_q & ~take) | press) : '0;
    end

    assign hit_valid = valid_q;
    assign hit_pos   = pos_q;
    assign btn_state = state_q;

endmodule

// File: tb/tb_mole_button_input.sv
// Directed bench for mole_button_input with a short debounce window (4 cycles).
module tb_mole_button_input;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] btn_raw;
    logic       en;
    logic       hit_ready;
    logic       hit_valid;
    logic [3:0] hit_pos;
    logic [7:0] btn_state;

    int vectors = 0;
    int miscompares = 0;
    int n_ev;
    logic [3:0] last_pos;

    mole_button_input #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_raw  (btn_raw),
        .en       (en),
        .hit_ready(hit_ready),
        .hit_valid(hit_valid),
        .hit_pos  (hit_pos),
        .btn_state(btn_state)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n cycles, counting cycles with hit_valid high and remembering the last hit_pos.
    task automatic watch(input int n, output int cnt, output logic [3:0] pos);
        cnt = 0;
        pos = '0;
        for (int i = 0; i < n; i++) begin
            tick(1);
            if (hit_valid === 1'b1) begin
                cnt++;
                pos = hit_pos;
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        btn_raw   = '0;
        en        = 1'b1;
        hit_ready = 1'b1;
        tick(3);
        check("reset_valid", 32'(hit_valid), 32'd0);
        check("reset_pos", 32'(hit_pos), 32'd0);
        check("reset_state", 32'(btn_state), 32'd0);
        rst_n = 1'b1;
        tick(4);

        // Clean press on hole 3
        btn_raw = 8'h04;
        tick(5);
        check("clean_state_early", 32'(btn_state), 32'h00);
        tick(1);
        check("clean_state", 32'(btn_state), 32'h04);
        check("clean_no_valid_yet", 32'(hit_valid), 32'd0);
        tick(1);
        check("clean_valid", 32'(hit_valid), 32'd1);
        check("clean_pos", 32'(hit_pos), 32'd3);
        tick(1);
        check("clean_valid_drop", 32'(hit_valid), 32'd0);
        check("clean_pos_zero", 32'(hit_pos), 32'd0);
        btn_raw = 8'h00;
        watch(10, n_ev, last_pos);
        check("release_no_event", 32'(n_ev), 32'd0);
        check("release_state", 32'(btn_state), 32'h00);

        // Bounce: 3-cycle pulse rejected, then held level accepted once
        btn_raw = 8'h01;
        tick(3);
        btn_raw = 8'h00;
        tick(1);
        btn_raw = 8'h01;
        tick(2);
        check("glitch_rejected", 32'(btn_state), 32'h00);
        watch(20, n_ev, last_pos);
        check("glitch_one_event", 32'(n_ev), 32'd1);
        check("glitch_pos", 32'(last_pos), 32'd1);
        btn_raw = 8'h00;
        tick(10);

        // Simultaneous presses on holes 2 and 5
        btn_raw = 8'h12;
        tick(6);
        check("simul_state", 32'(btn_state), 32'h12);
        tick(1);
        check("simul_valid0", 32'(hit_valid), 32'd1);
        check("simul_pos0", 32'(hit_pos), 32'd2);
        tick(1);
        check("simul_valid1", 32'(hit_valid), 32'd1);
        check("simul_pos1", 32'(hit_pos), 32'd5);
        tick(1);
        check("simul_done", 32'(hit_valid), 32'd0);
        btn_raw = 8'h00;
        tick(10);

        // Backpressure: hole 7 then hole 3 with hit_ready low
        hit_ready = 1'b0;
        btn_raw   = 8'h40;
        tick(7);
        check("bp_valid", 32'(hit_valid), 32'd1);
        check("bp_pos", 32'(hit_pos), 32'd7);
        btn_raw = 8'h44;
        tick(8);
        check("bp_hold_valid", 32'(hit_valid), 32'd1);
        check("bp_hold_pos", 32'(hit_pos), 32'd7);
        hit_ready = 1'b1;
        tick(1);
        check("bp_next_valid", 32'(hit_valid), 32'd1);
        check("bp_next_pos", 32'(hit_pos), 32'd3);
        tick(1);
        check("bp_empty", 32'(hit_valid), 32'd0);
        btn_raw = 8'h00;
        tick(10);

        // Enable gating on hole 5
        en      = 1'b0;
        btn_raw = 8'h10;
        watch(10, n_ev, last_pos);
        check("en_off_no_event", 32'(n_ev), 32'd0);
        check("en_off_state", 32'(btn_state), 32'h10);
        en = 1'b1;
        watch(10, n_ev, last_pos);
        check("en_held_no_event", 32'(n_ev), 32'd0);
        btn_raw = 8'h00;
        tick(10);
        btn_raw = 8'h10;
        watch(12, n_ev, last_pos);
        check("en_repress_event", 32'(n_ev), 32'd1);
        check("en_repress_pos", 32'(last_pos), 32'd5);
        btn_raw = 8'h00;
        tick(10);

        // Reset with a hit outstanding and two presses pending
        hit_ready = 1'b0;
        btn_raw   = 8'h07;
        tick(7);
        check("rst_pre_valid", 32'(hit_valid), 32'd1);
        check("rst_pre_pos", 32'(hit_pos), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_valid", 32'(hit_valid), 32'd0);
        check("rst_async_pos", 32'(hit_pos), 32'd0);
        check("rst_async_state", 32'(btn_state), 32'h00);
        tick(2);
        hit_ready = 1'b1;
        rst_n     = 1'b1;
        watch(15, n_ev, last_pos);
        check("rst_held_no_event", 32'(n_ev), 32'd0);
        check("rst_held_state", 32'(btn_state), 32'h07);
        btn_raw = 8'h00;
        tick(10);
        btn_raw = 8'h02;
        watch(12, n_ev, last_pos);
        check("rst_fresh_event", 32'(n_ev), 32'd1);
        check("rst_fresh_pos", 32'(last_pos), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
